// File: rtl/mem_copy_engine.sv
// mem_copy_engine: DataMemory bus master that copies a block of words from a
// source range to a destination range. When the destination starts inside the
// source range, the copy runs from the top down so that overlapping source words
// are read before they are overwritten (memmove semantics). Each word takes one
// READ cycle and one WRITE cycle. All outputs are registered Moore outputs.
//
//   state  | meaning
//   IDLE   | waiting for Start; memory outputs parked at zero
//   READ   | MemRead high, Adresa = source pointer, ReadData captured at edge
//   WRITE  | MemWrite high, Adresa = destination pointer, WriteData = buffer
//   FINISH | one-cycle Done pulse after normal completion

module mem_copy_engine #(
  parameter int AW = 24,
  parameter int DW = 24,
  parameter int LW = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [LW-1:0] Length,
  input  logic          Abort,
  output logic          Busy,
  output logic          Done,
  output logic [LW-1:0] WordsCopied,
  output logic [AW-1:0] Adresa,
  output logic [DW-1:0] WriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] ReadData
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] src_ptr_q;
  logic [AW-1:0] dst_ptr_q;
  logic [LW-1:0] remaining_q;
  logic          backward_q;
  logic [LW-1:0] words_q;
  logic          busy_q;
  logic          done_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic [AW-1:0] adr_q;
  // Holds the word read in READ; it is driven straight onto WriteData in WRITE
  // and is zero in every other state.
  logic [DW-1:0] wdata_q;

  logic [AW:0]   src_ext;
  logic [AW:0]   dst_ext;
  logic [AW:0]   span_end;
  logic [AW-1:0] len_m1;
  logic          backward_d;
  logic [AW-1:0] src_init_d;
  logic [AW-1:0] dst_init_d;
  logic [AW-1:0] src_step_d;
  logic [AW-1:0] dst_step_d;
  logic [LW-1:0] remaining_d;
  logic [LW-1:0] words_d;

  // Direction and starting pointers for a new copy, from the inputs sampled with
  // Start. The span end is one bit wider so a range touching the top of memory
  // does not wrap in the overlap compare.
  always_comb begin
    src_ext    = {1'b0, SrcAddr};
    dst_ext    = {1'b0, DstAddr};
    span_end   = src_ext + {{(AW + 1 - LW){1'b0}}, Length};
    len_m1     = {{(AW - LW){1'b0}}, Length} - {{(AW - 1){1'b0}}, 1'b1};
    backward_d = (dst_ext > src_ext) && (dst_ext < span_end);
    src_init_d = backward_d ? (SrcAddr + len_m1) : SrcAddr;
    dst_init_d = backward_d ? (DstAddr + len_m1) : DstAddr;
  end

  // Pointer stepping and counters for the WRITE commit; pointers wrap mod 2^AW.
  always_comb begin
    src_step_d  = backward_q ? (src_ptr_q - {{(AW - 1){1'b0}}, 1'b1})
                             : (src_ptr_q + {{(AW - 1){1'b0}}, 1'b1});
    dst_step_d  = backward_q ? (dst_ptr_q - {{(AW - 1){1'b0}}, 1'b1})
                             : (dst_ptr_q + {{(AW - 1){1'b0}}, 1'b1});
    remaining_d = remaining_q - {{(LW - 1){1'b0}}, 1'b1};
    words_d     = words_q + {{(LW - 1){1'b0}}, 1'b1};
  end

  // Copy sequencer: state, pointers and all registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      backward_q  <= 1'b0;
      words_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q   <= 1'b0;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          adr_q    <= '0;
          wdata_q  <= '0;
          if (Start) begin
            words_q <= '0;
            busy_q  <= 1'b1;
            if (Length != '0) begin
              state_q     <= S_READ;
              src_ptr_q   <= src_init_d;
              dst_ptr_q   <= dst_init_d;
              remaining_q <= Length;
              backward_q  <= backward_d;
              mem_rd_q    <= 1'b1;
              adr_q       <= src_init_d;
            end else begin
              // Zero-length request completes immediately with no bus traffic.
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end
          end
        end

        S_READ: begin
          mem_rd_q <= 1'b0;
          if (Abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
          end else begin
            state_q  <= S_WRITE;
            mem_wr_q <= 1'b1;
            adr_q    <= dst_ptr_q;
            wdata_q  <= ReadData;
          end
        end

        S_WRITE: begin
          // The write in flight commits at this edge even when aborting, so it
          // is always counted.
          mem_wr_q    <= 1'b0;
          wdata_q     <= '0;
          words_q     <= words_d;
          remaining_q <= remaining_d;
          src_ptr_q   <= src_step_d;
          dst_ptr_q   <= dst_step_d;
          if (Abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            adr_q   <= '0;
          end else if (remaining_d == '0) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
            adr_q   <= '0;
          end else begin
            state_q  <= S_READ;
            mem_rd_q <= 1'b1;
            adr_q    <= src_step_d;
          end
        end

        S_FINISH: begin
          state_q  <= S_IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          adr_q    <= '0;
          wdata_q  <= '0;
        end

        default: begin
          state_q  <= S_IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          adr_q    <= '0;
          wdata_q  <= '0;
        end
      endcase
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign WordsCopied = words_q;
  assign Adresa      = adr_q;
  assign WriteData   = wdata_q;
  assign MemWrite    = mem_wr_q;
  assign MemRead     = mem_rd_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a small DataMemory model, a reference copy model
// over a sparse memory image, and a monitor that checks every bus cycle against
// queues of expected reads and writes.

module tb_mem_copy_engine;

  logic        Clock = 1'b0;
  logic        Reset, Start, Abort;
  logic [23:0] SrcAddr, DstAddr;
  logic [15:0] Length;
  logic        Busy, Done, MemWrite, MemRead;
  logic [15:0] WordsCopied;
  logic [23:0] Adresa, WriteData, ReadData;

  mem_copy_engine #(.AW(24), .DW(24), .LW(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .SrcAddr(SrcAddr),
    .DstAddr(DstAddr), .Length(Length), .Abort(Abort), .Busy(Busy),
    .Done(Done), .WordsCopied(WordsCopied), .Adresa(Adresa),
    .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData)
  );

  always #5 Clock = ~Clock;

  // DataMemory: 1024 words, indexed by the low address bits.
  logic [23:0] mem [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [23:0] pl_data = '0;

  assign ReadData = MemRead ? mem[Adresa[9:0]] : 24'd0;

  always @(posedge Clock) begin
    if (MemWrite) mem[Adresa[9:0]] <= WriteData;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  // Reference memory image (full 24-bit addresses) and scoreboard queues.
  logic [23:0] ref_mem [int];
  typedef struct packed { logic [23:0] a; logic [23:0] d; } wr_t;
  logic [23:0] exp_rd[$];
  wr_t         exp_wr[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every bus cycle must match the head of the expected queue.
  always @(negedge Clock) begin
    if (MemRead && MemWrite) chk("rd_wr_both", 1, 0);
    if (MemRead) begin
      if (exp_rd.size() == 0) chk("unexpected_read", Adresa, 24'hxxxxxx === 0);
      else chk("read_addr", Adresa, exp_rd.pop_front());
    end
    if (MemWrite) begin
      if (exp_wr.size() == 0) chk("unexpected_write", Adresa, 24'hxxxxxx === 0);
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("write_addr", Adresa, w.a);
        chk("write_data", WriteData, w.d);
      end
    end
  end

  task automatic preload(input logic [23:0] a, input logic [23:0] d);
    pl_we = 1'b1; pl_addr = a[9:0]; pl_data = d;
    ref_mem[int'(a)] = d;
    @(posedge Clock); #1;
    pl_we = 1'b0;
  endtask

  // One copy: builds expectations from the reference model, drives Start,
  // optionally aborts in the WRITE of word abort_k or resets in cycle reset_c.
  task automatic run_copy(input logic [23:0] src, input logic [23:0] dst,
                          input int len, input int abort_k, input int reset_c,
                          input bit busy_start);
    longint   s, d;
    bit       bwd;
    int       committed, exp_done, done_c, stop_c, limit, pat_bad, mem_bad;
    logic [23:0] ra, wa, v;
    wr_t      w;
    s = longint'(src); d = longint'(dst);
    bwd = (d > s) && (d < s + len);
    committed = (abort_k >= 0) ? abort_k + 1 : (reset_c > 0) ? (reset_c - 1) / 2 : len;
    for (int j = 0; j < len; j++) begin
      int i;
      i  = bwd ? (len - 1 - j) : j;
      ra = src + 24'(i);
      wa = dst + 24'(i);
      v  = ref_mem.exists(int'(ra)) ? ref_mem[int'(ra)] : 24'd0;
      exp_rd.push_back(ra);
      w.a = wa; w.d = v;
      exp_wr.push_back(w);
      if (j < committed) ref_mem[int'(wa)] = v;
    end
    exp_done = (abort_k >= 0 || reset_c > 0) ? 0 : 2 * len + 1;
    stop_c   = (abort_k >= 0) ? 2 * abort_k + 3 : (reset_c > 0) ? reset_c + 1 : 2 * len + 12;
    limit    = (abort_k >= 0) ? 2 * abort_k + 2 : (reset_c > 0) ? reset_c : 2 * len;

    SrcAddr = src; DstAddr = dst; Length = 16'(len); Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    done_c = 0; pat_bad = 0;
    for (int c = 1; c <= stop_c; c++) begin
      Abort = (abort_k >= 0) && (c == 2 * abort_k + 2);
      Reset = (reset_c > 0) && (c == reset_c);
      if (busy_start && c == 2) begin
        Start = 1'b1; SrcAddr = 24'h200; DstAddr = 24'h300; Length = 16'd7;
      end else Start = 1'b0;
      @(negedge Clock);
      if (c <= limit && c <= 2 * len)
        if (MemRead !== c[0] || MemWrite !== !c[0]) pat_bad++;
      if (Done === 1'b1 && done_c == 0) done_c = c;
      if (abort_k >= 0 && c == stop_c) chk("busy_after_abort", Busy, 0);
      if (reset_c > 0 && c == stop_c)
        chk("outs_after_reset", {Busy, Done, MemWrite, MemRead, Adresa, WriteData, WordsCopied}, 0);
      if (exp_done != 0 && done_c != 0) break;
      @(posedge Clock); #1;
    end
    Abort = 1'b0; Reset = 1'b0; Start = 1'b0;
    chk("done_cycle", done_c, exp_done);
    chk("rw_pattern", pat_bad, 0);
    @(posedge Clock); #1;
    if (exp_done != 0) begin
      @(negedge Clock);
      chk("done_pulse_one_cycle", {Done, Busy}, 2'b00);
      chk("rd_queue_empty", exp_rd.size(), 0);
      chk("wr_queue_empty", exp_wr.size(), 0);
    end
    exp_rd.delete(); exp_wr.delete();
    chk("words_copied", WordsCopied, (reset_c > 0) ? 0 : committed);
    mem_bad = 0;
    foreach (ref_mem[k]) begin
      logic [23:0] ka;
      ka = 24'(k);
      if (mem[ka[9:0]] !== ref_mem[k]) mem_bad++;
    end
    chk("mem_image", mem_bad, 0);
    @(posedge Clock); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 24'd0;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0;
    SrcAddr = '0; DstAddr = '0; Length = '0;
    repeat (2) @(posedge Clock);
    #1;
    @(negedge Clock);
    chk("reset_state", {Busy, Done, MemWrite, MemRead, Adresa, WriteData, WordsCopied}, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Forward copy, no overlap.
    preload(24'd3, 24'd14); preload(24'd4, 24'd15); preload(24'd5, 24'd16);
    run_copy(24'd3, 24'd10, 3, -1, 0, 1'b0);

    // Zero length must still pulse Done in cycle 1 and keep WordsCopied at 0.
    run_copy(24'd3, 24'd10, 0, -1, 0, 1'b0);

    // Overlap, destination above source: backward.
    for (int i = 0; i < 4; i++) preload(24'(3 + i), 24'(1 + i));
    run_copy(24'd3, 24'd5, 4, -1, 0, 1'b0);

    // Overlap, destination below source: forward.
    for (int i = 0; i < 4; i++) preload(24'(5 + i), 24'(1 + i));
    run_copy(24'd5, 24'd3, 4, -1, 0, 1'b0);

    // Source range wraps past the top of the address space.
    preload(24'hFFFFFE, 24'hA1); preload(24'hFFFFFF, 24'hA2); preload(24'h000000, 24'hA3);
    run_copy(24'hFFFFFE, 24'h000000, 3, -1, 0, 1'b0);

    // Abort in the second WRITE, with a Start issued while busy.
    for (int i = 0; i < 5; i++) preload(24'(40 + i), 24'(100 + i));
    run_copy(24'd40, 24'd60, 5, 1, 0, 1'b1);

    // Reset during the second READ, then a normal copy.
    for (int i = 0; i < 4; i++) preload(24'(70 + i), 24'(200 + i));
    run_copy(24'd70, 24'd80, 4, -1, 3, 1'b0);
    run_copy(24'd70, 24'd90, 4, -1, 0, 1'b0);

    // Randomized copies in a small window so overlaps are frequent.
    for (int n = 0; n < 14; n++) begin
      logic [23:0] s, d;
      int len;
      s   = 24'($urandom_range(100, 140));
      d   = 24'($urandom_range(100, 140));
      len = $urandom_range(0, 10);
      for (int i = 0; i < len; i++) preload(s + 24'(i), 24'($urandom));
      if (n % 5 == 4 && len > 1)
        run_copy(s, d, len, $urandom_range(0, len - 1), 0, 1'b0);
      else
        run_copy(s, d, len, -1, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus-master initiator for the DataMemory interface. It drives Adresa, WriteData, MemWrite and MemRead, and consumes ReadData.
- It copies a block of 24-bit words from a source address range to a destination address range without CPU involvement, with memmove-safe ordering when the ranges overlap.
- It sits beside the CPU datapath. A top-level mux, outside this block, grants it the DataMemory port while Busy=1.

Parameters:
- AW, 24, address width (Adresa, SrcAddr, DstAddr).
- DW, 24, data word width (WriteData, ReadData).
- LW, 16, width of the Length and WordsCopied fields.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request to begin a copy; sampled only in IDLE.
- SrcAddr  in  AW  first source word address; sampled with Start.
- DstAddr  in  AW  first destination word address; sampled with Start.
- Length  in  LW  number of words to copy; sampled with Start.
- Abort  in  1  terminates an active copy.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse on normal completion.
- WordsCopied  out  LW  count of destination writes committed in the current or last copy.
- Adresa  out  AW  memory address.
- WriteData  out  DW  memory write data.
- MemWrite  out  1  memory write enable; DataMemory commits on the rising Clock edge while it is high.
- MemRead  out  1  memory read enable; DataMemory presents ReadData combinationally in the same cycle.
- ReadData  in  DW  memory read data.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Busy, Done, MemWrite, MemRead are 0; Adresa and WriteData are 0; WordsCopied is 0; internal pointers and buffer are 0.
  - A WRITE cycle in progress during the Reset cycle still commits in memory, because MemWrite was high at that edge. This is accepted behaviour.
- Memory-side outputs are Moore outputs decoded from state and registers. In IDLE and FINISH: MemRead=0, MemWrite=0, Adresa=0, WriteData=0.
- States: IDLE, READ, WRITE, FINISH.
- IDLE:
  - Start=1 and Length≠0: latch parameters, WordsCopied←0, go to READ.
  - Start=1 and Length=0: WordsCopied←0, go to FINISH.
  - Otherwise stay in IDLE.
- Direction is decided at Start using 25-bit unsigned arithmetic:
  - Backward if DstAddr>SrcAddr and DstAddr<SrcAddr+Length. Pointers are then initialised to SrcAddr+Length-1 and DstAddr+Length-1, and decrement.
  - Otherwise forward: pointers start at SrcAddr and DstAddr, and increment.
  - Pointers wrap modulo 2^AW.
- READ: MemRead=1, Adresa=src pointer. At the edge, buffer←ReadData; go to WRITE.
- WRITE: MemWrite=1, Adresa=dst pointer, WriteData=buffer. At the edge:
  - WordsCopied+1; remaining−1; both pointers step.
  - If remaining reaches 0, go to FINISH; else go to READ.
- FINISH: Done=1 for exactly one cycle, then IDLE.
- Busy=1 in READ, WRITE and FINISH.
- Latency: with Start accepted at edge E0, word k (k=0..N-1) is read in cycle 2k+1 and written in cycle 2k+2. Done is high in cycle 2N+1, and Busy falls after it. Throughput is 2 cycles per word.
- Start while Busy is ignored; no queueing.
- Abort=1 in READ or WRITE: go to IDLE at that edge, with no Done pulse.
  - If aborted in WRITE, that write commits and WordsCopied counts it.
  - Abort in IDLE or FINISH has no effect; a FINISH Done still pulses.
- Reset has priority over Abort, and Abort has priority over Start.
- WordsCopied holds its final value in IDLE until the next accepted Start.
- Src==Dst: the copy proceeds forward normally; each word is rewritten with itself.

Test Plan:
- Forward copy: preload mem[3..5]=14,15,16; Start with Src=3, Dst=10, Len=3 → mem[10..12]=14,15,16; Done high in cycle 7; WordsCopied=3; MemRead/MemWrite alternate, starting with a read.
- Overlap backward: mem[3..6]=1,2,3,4; Src=3, Dst=5, Len=4 → mem[5..8]=1,2,3,4; first write address=8, last write address=5.
- Overlap forward: mem[5..8]=1,2,3,4; Src=5, Dst=3, Len=4 → mem[3..6]=1,2,3,4; write addresses ascend 3..6.
- Zero length / wrap: Len=0 → Done in cycle 1 with no MemRead/MemWrite; then Src=24'hFFFFFE, Dst=0, Len=3 → reads from FFFFFE, FFFFFF, 0, in that order.
- Abort: Len=5, assert Abort in the 2nd WRITE cycle → mem gets 2 words, WordsCopied=2, no Done, Busy=0 next cycle; Start during Busy is ignored.
- Reset mid-copy: Reset asserted in a READ cycle → next cycle all outputs are 0 and state is IDLE; a following Start runs normally.
